// File: rtl/maze_pkg.sv
// Shared types and helpers for the wavefront maze solver.
// No logic of its own; is_wall() treats anything off-grid as a wall.
// No flow control here.
package maze_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FLOOD,
      ST_TRACE,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      DIR_N = 2'd0,
      DIR_E = 2'd1,
      DIR_S = 2'd2,
      DIR_W = 2'd3
   } dir_t;

   localparam int MAX_CELLS = 4096;
   localparam int MAX_IW    = $clog2(MAX_CELLS);

   // flat holds wall bits at index y*w+x; padding above w*h is don't-care
   function automatic logic is_wall(input int x, input int y, input int w, input int h,
                                    input logic [MAX_CELLS-1:0] flat);
      logic [MAX_IW-1:0] idx;
      if (x < 0 || x >= w || y < 0 || y >= h) begin
         return 1'b1;
      end
      idx = MAX_IW'(y * w + x);
      return flat[idx];
   endfunction

endpackage

// File: rtl/maze_flood_cell.sv
// One grid cell of the BFS wavefront: visited flag plus the direction it was reached from.
// Latency: becomes visited one cycle after any enabled neighbour is visited.
// No backpressure; clr_i has priority over en_i and loads seed_i.
module maze_flood_cell
   import maze_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr_i,
   input  logic       seed_i,
   input  logic       en_i,
   input  logic       wall_i,
   input  logic [3:0] nb_vis_i,
   output logic       visited_o,
   output logic       newly_set_o,
   output dir_t       dir_o
);

   logic visited_q, visited_d;
   dir_t dir_q, dir_d;
   dir_t first_dir;

   // nb_vis_i is indexed by dir_t, so lowest set bit is the highest priority
   always_comb begin
      if (nb_vis_i[0]) begin
         first_dir = DIR_N;
      end else if (nb_vis_i[1]) begin
         first_dir = DIR_E;
      end else if (nb_vis_i[2]) begin
         first_dir = DIR_S;
      end else begin
         first_dir = DIR_W;
      end
   end

   assign newly_set_o = en_i && !visited_q && !wall_i && (|nb_vis_i);

   always_comb begin
      visited_d = visited_q;
      dir_d     = dir_q;
      if (clr_i) begin
         visited_d = seed_i;
         dir_d     = DIR_N;
      end else if (newly_set_o) begin
         visited_d = 1'b1;
         dir_d     = first_dir;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         visited_q <= 1'b0;
         dir_q     <= DIR_N;
      end else begin
         visited_q <= visited_d;
         dir_q     <= dir_d;
      end
   end

   assign visited_o = visited_q;
   assign dir_o     = dir_q;

endmodule

// File: rtl/maze_wavefront_solver.sv
// Shortest-path maze solver: one BFS layer per cycle, then a one-cell-per-cycle backtrace.
// Latency: 2d+2 cycles from accepted start for a path of distance d; 2 cycles for a bad request.
// start is only accepted in IDLE or DONE; it is ignored while busy.
module maze_wavefront_solver
   import maze_pkg::*;
#(
   parameter int W  = 15,
   parameter int H  = 15,
   parameter int XW = $clog2(W),
   parameter int YW = $clog2(H),
   parameter int LW = $clog2(W*H+1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [H-1:0][W-1:0] maze,
   input  logic [XW-1:0]       sx,
   input  logic [YW-1:0]       sy,
   input  logic [XW-1:0]       ex,
   input  logic [YW-1:0]       ey,
   output logic                busy,
   output logic                done,
   output logic                found,
   output logic [H-1:0][W-1:0] path,
   output logic [LW-1:0]       path_len
);

   localparam int N  = W * H;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   state_t              state_q;
   logic [H-1:0][W-1:0] maze_q;
   logic [H-1:0][W-1:0] path_q;
   logic [XW-1:0]       sx_q, ex_q, cur_x_q;
   logic [YW-1:0]       sy_q, ey_q, cur_y_q;
   logic [LW-1:0]       path_len_q;
   logic                busy_q, done_q, found_q, invalid_q;

   logic [MAX_CELLS-1:0] maze_flat;
   logic                 req_ok;
   logic [CW-1:0]        src_idx, exit_idx, cur_idx;
   logic                 clr_cells, en_cells, any_new;
   logic [N-1:0]         vis, newly;
   dir_t                 cell_dir [N];

   assign maze_flat = {{(MAX_CELLS - N){1'b1}}, maze_q};
   assign req_ok    = !is_wall(int'(sx_q), int'(sy_q), W, H, maze_flat) &&
                      !is_wall(int'(ex_q), int'(ey_q), W, H, maze_flat);

   assign src_idx  = CW'(int'(sy_q) * W + int'(sx_q));
   assign exit_idx = CW'(int'(ey_q) * W + int'(ex_q));
   assign cur_idx  = CW'(int'(cur_y_q) * W + int'(cur_x_q));

   assign clr_cells = (state_q == ST_LOAD);
   assign en_cells  = (state_q == ST_FLOOD) && !invalid_q;
   assign any_new   = |newly;

   for (genvar gy = 0; gy < H; gy++) begin : g_row
      for (genvar gx = 0; gx < W; gx++) begin : g_col
         localparam int I = gy * W + gx;
         logic [3:0] nb;

         // Off-grid neighbours read as unvisited, so there is no wrap-around
         if (gy > 0)     begin : g_n  assign nb[0] = vis[I-W]; end else begin : g_n0 assign nb[0] = 1'b0; end
         if (gx < W - 1) begin : g_e  assign nb[1] = vis[I+1]; end else begin : g_e0 assign nb[1] = 1'b0; end
         if (gy < H - 1) begin : g_s  assign nb[2] = vis[I+W]; end else begin : g_s0 assign nb[2] = 1'b0; end
         if (gx > 0)     begin : g_w  assign nb[3] = vis[I-1]; end else begin : g_w0 assign nb[3] = 1'b0; end

         maze_flood_cell u_cell (
            .clk         (clk),
            .rst_n       (rst_n),
            .clr_i       (clr_cells),
            .seed_i      (req_ok && (src_idx == CW'(I))),
            .en_i        (en_cells),
            .wall_i      (maze_q[gy][gx]),
            .nb_vis_i    (nb),
            .visited_o   (vis[I]),
            .newly_set_o (newly[I]),
            .dir_o       (cell_dir[I])
         );
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         maze_q     <= '0;
         sx_q       <= '0;
         sy_q       <= '0;
         ex_q       <= '0;
         ey_q       <= '0;
         cur_x_q    <= '0;
         cur_y_q    <= '0;
         path_q     <= '0;
         path_len_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         found_q    <= 1'b0;
         invalid_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_q    <= ST_LOAD;
                  maze_q     <= maze;
                  sx_q       <= sx;
                  sy_q       <= sy;
                  ex_q       <= ex;
                  ey_q       <= ey;
                  path_q     <= '0;
                  path_len_q <= '0;
                  found_q    <= 1'b0;
                  done_q     <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            ST_LOAD: begin
               // A rejected request still spends one FLOOD cycle with the cells idle
               invalid_q <= !req_ok;
               cur_x_q   <= ex_q;
               cur_y_q   <= ey_q;
               if (req_ok && (sx_q == ex_q) && (sy_q == ey_q)) begin
                  state_q <= ST_TRACE;
               end else begin
                  state_q <= ST_FLOOD;
               end
            end
            ST_FLOOD: begin
               if (invalid_q) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else if (newly[exit_idx]) begin
                  state_q <= ST_TRACE;
               end else if (!any_new) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            ST_TRACE: begin
               path_q[cur_y_q][cur_x_q] <= 1'b1;
               path_len_q               <= path_len_q + LW'(1);
               if ((cur_x_q == sx_q) && (cur_y_q == sy_q)) begin
                  state_q <= ST_DONE;
                  found_q <= 1'b1;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  case (cell_dir[cur_idx])
                     DIR_N:   cur_y_q <= cur_y_q - YW'(1);
                     DIR_E:   cur_x_q <= cur_x_q + XW'(1);
                     DIR_S:   cur_y_q <= cur_y_q + YW'(1);
                     default: cur_x_q <= cur_x_q - XW'(1);
                  endcase
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign found    = found_q;
   assign path     = path_q;
   assign path_len = path_len_q;

endmodule
